mips_multicycle_controller: RTL and testbench

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It produces the 2-bit `alu_op` consumed directly by `alu_decoder`, which combines it with `funct` to form `alu_control`. It also adds a memory-ready handshake so instruction and data memory may take more than one cycle.

---
 rtl/mips_multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS main control FSM with memory-ready handshake on fetch, load and store.
// Optional macro MIPS_ADDI_EN adds the addi path (ADDIEXEC -> ADDIWB); otherwise opcode 001000 is illegal.
module mips_multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q;
    state_t decode_next;
    logic   decode_illegal;

    always_comb begin
        decode_next    = FETCH;
        decode_illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW: decode_next = MEMADR;
            OP_RTYPE:     decode_next = EXECUTE;
            OP_BEQ:       decode_next = BRANCH;
`ifdef MIPS_ADDI_EN
            OP_ADDI:      decode_next = ADDIEXEC;
`endif
            OP_J:         decode_next = JUMP;
            default:      decode_illegal = 1'b1;
        endcase
    end

    // Unreachable encodings (12-15, and 9/10 without addi) recover to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:    state_q <= mem_ready ? DECODE : FETCH;
                DECODE:   state_q <= decode_next;
                MEMADR:   state_q <= (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:    state_q <= mem_ready ? MEMWB : MEMRD;
                MEMWB:    state_q <= FETCH;
                MEMWR:    state_q <= mem_ready ? FETCH : MEMWR;
                EXECUTE:  state_q <= ALUWB;
                ALUWB:    state_q <= FETCH;
                BRANCH:   state_q <= FETCH;
`ifdef MIPS_ADDI_EN
                ADDIEXEC: state_q <= ADDIWB;
                ADDIWB:   state_q <= FETCH;
`endif
                JUMP:     state_q <= FETCH;
                default:  state_q <= FETCH;
            endcase
        end
    end

    assign state = state_q;

    always_comb begin
        alu_op     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = decode_illegal;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
`ifdef MIPS_ADDI_EN
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
`endif
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides the current state's outputs: enables off, selects as in FETCH.
        if (reset) begin
            alu_op     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            pc_src     = 2'b00;
            iord       = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for mips_multicycle_controller: per-cycle vector table plus hand-written stall/reset sequences.
// Expectations for opcode 001000 follow the MIPS_ADDI_EN build setting.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state;

    mips_multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .iord       (iord),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] o;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] o;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    logic [15:0] act;
    assign act = {alu_op, alu_src_a, alu_src_b, pc_src, iord, reg_dst, mem_to_reg,
                  ir_write, pc_write, branch, mem_write, reg_write, illegal_op};

    function automatic logic [15:0] mk(input logic [1:0] aop, input logic sa, input logic [1:0] sb_sel,
                                       input logic [1:0] ps, input logic io, input logic rd, input logic m2r,
                                       input logic irw, input logic pcw, input logic br, input logic mw,
                                       input logic rw, input logic ill);
        return {aop, sa, sb_sel, ps, io, rd, m2r, irw, pcw, br, mw, rw, ill};
    endfunction

    logic [15:0] o_idle, o_fetch, o_dec, o_dec_ill, o_memadr, o_memrd, o_memwb, o_memwr;
    logic [15:0] o_exec, o_aluwb, o_br, o_addiwb, o_jump;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [15:0] o);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.o = o;
        tbl.push_back(v);
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty cycle %0d", cyc);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (state !== e.st) begin
            errors++;
            $display("FAIL state cycle %0d actual %0d required %0d", cyc, state, e.st);
        end
        checks++;
        if (act !== e.o) begin
            errors++;
            $display("FAIL outputs cycle %0d state %0d actual %b required %b", cyc, state, act, e.o);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check settled outputs before the rising edge.
    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                        input logic [15:0] o);
        exp_t e;
        @(negedge clk);
        reset = r;
        opcode = op;
        mem_ready = rdy;
        e.st = st;
        e.o = o;
        sb.push_back(e);
        #1;
        cyc++;
        check_front();
    endtask

    initial begin
        o_idle    = mk(2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_fetch   = mk(2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        o_dec     = mk(2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_dec_ill = mk(2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        o_memadr  = mk(2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_memrd   = mk(2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        o_memwb   = mk(2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        o_memwr   = mk(2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        o_exec    = mk(2'b10, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_aluwb   = mk(2'b00, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        o_br      = mk(2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        o_addiwb  = mk(2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        o_jump    = mk(2'b00, 0, 2'b00, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // lw: 0,1,2,3,4 then FETCH
        add(0, LW, 1, 4'd0, o_fetch);
        add(0, LW, 1, 4'd1, o_dec);
        add(0, LW, 1, 4'd2, o_memadr);
        add(0, LW, 1, 4'd3, o_memrd);
        add(0, LW, 1, 4'd4, o_memwb);
        // R-type: 0,1,6,7
        add(0, RT, 1, 4'd0, o_fetch);
        add(0, RT, 1, 4'd1, o_dec);
        add(0, RT, 1, 4'd6, o_exec);
        add(0, RT, 1, 4'd7, o_aluwb);
        // beq: 0,1,8
        add(0, BEQ, 1, 4'd0, o_fetch);
        add(0, BEQ, 1, 4'd1, o_dec);
        add(0, BEQ, 1, 4'd8, o_br);
        // j: 0,1,11
        add(0, J, 1, 4'd0, o_fetch);
        add(0, J, 1, 4'd1, o_dec);
        add(0, J, 1, 4'd11, o_jump);
        // illegal opcode pulses in DECODE and returns to FETCH
        add(0, BAD, 1, 4'd0, o_fetch);
        add(0, BAD, 1, 4'd1, o_dec_ill);
        // addi
        add(0, ADDI, 1, 4'd0, o_fetch);
`ifdef MIPS_ADDI_EN
        add(0, ADDI, 1, 4'd1, o_dec);
        add(0, ADDI, 1, 4'd9, o_memadr);
        add(0, ADDI, 1, 4'd10, o_addiwb);
`else
        add(0, ADDI, 1, 4'd1, o_dec_ill);
`endif
        // lw with stalls in FETCH and MEMRD
        add(0, LW, 0, 4'd0, o_idle);
        add(0, LW, 1, 4'd0, o_fetch);
        add(0, LW, 1, 4'd1, o_dec);
        add(0, LW, 1, 4'd2, o_memadr);
        add(0, LW, 0, 4'd3, o_memrd);
        add(0, LW, 1, 4'd3, o_memrd);
        add(0, LW, 1, 4'd4, o_memwb);
        add(0, J, 1, 4'd0, o_fetch);

        reset = 1'b1;
        opcode = RT;
        mem_ready = 1'b1;
        @(negedge clk);
        // Second reset cycle: state is FETCH, enables forced low even with mem_ready high.
        step(1, RT, 1, 4'd0, o_idle);

        foreach (tbl[i]) step(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].o);

        // sw with mem_ready low for 3 cycles in MEMWR: mem_write held 4 cycles
        step(0, J, 1, 4'd1, o_dec);
        step(0, J, 1, 4'd11, o_jump);
        step(0, SW, 1, 4'd0, o_fetch);
        step(0, SW, 1, 4'd1, o_dec);
        step(0, SW, 1, 4'd2, o_memadr);
        step(0, SW, 0, 4'd5, o_memwr);
        step(0, SW, 0, 4'd5, o_memwr);
        step(0, SW, 0, 4'd5, o_memwr);
        step(0, SW, 1, 4'd5, o_memwr);
        step(0, SW, 1, 4'd0, o_fetch);

        // reset for 2 cycles mid-MEMWR with mem_ready low
        step(0, SW, 1, 4'd1, o_dec);
        step(0, SW, 1, 4'd2, o_memadr);
        step(0, SW, 0, 4'd5, o_memwr);
        step(1, SW, 0, 4'd5, o_idle);
        step(1, SW, 0, 4'd0, o_idle);
        step(0, SW, 0, 4'd0, o_idle);
        step(0, SW, 1, 4'd0, o_fetch);
        step(0, SW, 1, 4'd1, o_dec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
